// File: rtl/regfile_write_ctrl.sv
// regfile_write_ctrl
//   Owns the single write port of the register file. After reset it sweeps
//   every register to zero, because the file itself has no reset. It then
//   shares the port between the pipeline WB stage and a long-latency unit (LU)
//   that uses a valid/ready handshake.
//
//   WB normally has priority. An LU request that keeps losing to WB is forced
//   through after MAX_WAIT consecutive losses. In that case WB is stalled and
//   must be re-presented on the next cycle.
//
// Ports
//   clk_i, rst_i            clock (rising edge); synchronous active-high reset
//   wb_we_i/addr_i/data_i   WB write request; no back-pressure, held while stall_o=1
//   lu_valid_i/addr_i/data_i LU write request; held stable while valid & !ready
//   lu_ready_o              LU request accepted this cycle
//   stall_o                 freeze the pipeline so WB is re-presented next cycle
//   init_done_o             zero sweep finished
//   regwrite_o/rdaddr_o/rddata_o  write port of the register file
//
//   All outputs are combinational. The write commits at the next clk_i edge.
module regfile_write_ctrl #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wb_we_i,
  input  logic [ADDR_W-1:0] wb_addr_i,
  input  logic [DATA_W-1:0] wb_data_i,
  input  logic              lu_valid_i,
  input  logic [ADDR_W-1:0] lu_addr_i,
  input  logic [DATA_W-1:0] lu_data_i,
  output logic              lu_ready_o,
  output logic              stall_o,
  output logic              init_done_o,
  output logic              regwrite_o,
  output logic [ADDR_W-1:0] rdaddr_o,
  output logic [DATA_W-1:0] rddata_o
);

  // Keep the counter at least one bit wide so that MAX_WAIT=0 still elaborates.
  localparam int WAIT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

  logic wb_req;
  logic force_lu;
  logic grant_wb;
  logic grant_lu;

  // Arbitration. A WB write to $0 is not a request, so it never blocks the LU.
  always_comb begin
    wb_req   = wb_we_i && (wb_addr_i != '0);
    force_lu = (wait_cnt_q == WAIT_W'(MAX_WAIT));
    grant_wb = (state_q == ST_RUN) && wb_req && !(lu_valid_i && force_lu);
    grant_lu = (state_q == ST_RUN) && !grant_wb && lu_valid_i;
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Next state
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      ST_INIT: begin
        init_cnt_d = init_cnt_q + ADDR_W'(1);
        wait_cnt_d = '0;
        if (init_cnt_q == {ADDR_W{1'b1}}) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!lu_valid_i || grant_lu) begin
          wait_cnt_d = '0;
        end else if (wait_cnt_q != WAIT_W'(MAX_WAIT)) begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Outputs
  always_comb begin
    regwrite_o  = 1'b0;
    rdaddr_o    = '0;
    rddata_o    = '0;
    lu_ready_o  = 1'b0;
    stall_o     = 1'b0;
    init_done_o = 1'b0;
    if (rst_i) begin
      // Behave as the first sweep cycle so that a pending LU is never accepted.
      regwrite_o = 1'b1;
      stall_o    = 1'b1;
    end else begin
      case (state_q)
        ST_INIT: begin
          regwrite_o = 1'b1;
          rdaddr_o   = init_cnt_q;
          stall_o    = 1'b1;
        end
        ST_RUN: begin
          init_done_o = 1'b1;
          if (grant_wb) begin
            regwrite_o = 1'b1;
            rdaddr_o   = wb_addr_i;
            rddata_o   = wb_data_i;
          end else if (grant_lu) begin
            // An LU write to $0 is accepted but is not written.
            lu_ready_o = 1'b1;
            stall_o    = wb_req;
            regwrite_o = (lu_addr_i != '0);
            rdaddr_o   = lu_addr_i;
            rddata_o   = lu_data_i;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
